// File: rtl/ibex_l2_regfile_resp.sv
// L2 register store responder: flop array with a configurable read latency and a
// one-entry posted write buffer that forwards to reads and drains on non-read cycles.
module ibex_l2_regfile_resp #(
  parameter int DataWidth   = 32,
  parameter int AddrWidth   = 5,
  parameter int NumWords    = 32,
  parameter int ReadLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 err_o,
  output logic                 busy_o
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_WAIT = 1'b1;

  localparam int                 IdxW      = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [AddrWidth:0] NumWordsW = (AddrWidth + 1)'(NumWords);
  localparam logic [1:0]         LatInit   = 2'(ReadLatency - 1);

  logic [0:0]           state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [AddrWidth-1:0] wb_addr_q, wb_addr_d;
  logic [DataWidth-1:0] wb_data_q, wb_data_d;
  logic [DataWidth-1:0] mem_q [NumWords];

  logic [ReadLatency-1:0] pv_q;
  logic [ReadLatency-1:0] pe_q;
  logic [DataWidth-1:0]   pd_q [ReadLatency];

  logic                 addr_in_range, addr_zero;
  logic                 rd_launch, wr_capture, wb_commit;
  logic [DataWidth-1:0] rd_data_s;
  logic                 rd_err_s;

  assign gnt_o         = (state_q == IDLE);
  assign addr_in_range = ({1'b0, addr_i} < NumWordsW);
  assign addr_zero     = (addr_i == '0);
  assign rd_launch     = req_i & gnt_o & ~we_i;
  assign wr_capture    = req_i & gnt_o & we_i & addr_in_range & ~addr_zero;
  // The single array port is free whenever no read launches this cycle.
  assign wb_commit     = wb_valid_q & ~rd_launch;

  always_comb begin
    rd_data_s = '0;
    rd_err_s  = ~addr_in_range;
    if (addr_in_range && !addr_zero) begin
      if (wb_valid_q && (wb_addr_q == addr_i)) begin
        rd_data_s = wb_data_q;
      end else begin
        rd_data_s = mem_q[addr_i[IdxW-1:0]];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rd_launch) begin
          cnt_d = LatInit;
          if (ReadLatency > 1) state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_valid_d = wr_capture | (wb_valid_q & rd_launch);
    wb_addr_d  = wr_capture ? addr_i  : wb_addr_q;
    wb_data_d  = wr_capture ? wdata_i : wb_data_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Entry 0 is never a commit target since writes to it are dropped at capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
    end else if (wb_commit) begin
      mem_q[wb_addr_q[IdxW-1:0]] <= wb_data_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int i = 0; i < ReadLatency; i++) pd_q[i] <= '0;
    end else begin
      pv_q[0] <= rd_launch;
      pe_q[0] <= rd_launch & rd_err_s;
      pd_q[0] <= rd_launch ? rd_data_s : '0;
      for (int i = 1; i < ReadLatency; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign rvalid_o = pv_q[ReadLatency-1];
  assign err_o    = pe_q[ReadLatency-1];
  assign rdata_o  = pv_q[ReadLatency-1] ? pd_q[ReadLatency-1] : '0;
  assign busy_o   = wb_valid_q | (state_q != IDLE) | (|pv_q);

endmodule

// File: tb/tb_ibex_l2_regfile_resp.sv
// Bench for ibex_l2_regfile_resp: directed scenarios plus random traffic checked
// against an architectural register model with a timed response queue.
module tb_ibex_l2_regfile_resp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NW = 16;
  localparam int RL = 3;

  logic          clk, rst_n;
  logic          req, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt, rvalid, err, busy;
  logic [DW-1:0] rdata;

  ibex_l2_regfile_resp #(
    .DataWidth  (DW),
    .AddrWidth  (AW),
    .NumWords   (NW),
    .ReadLatency(RL)
  ) u_dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .gnt_o   (gnt),
    .rvalid_o(rvalid),
    .rdata_o (rdata),
    .err_o   (err),
    .busy_o  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    bit            err;
  } rsp_t;

  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc   = 0;
  logic [DW-1:0] ref_regs [NW];
  rsp_t          rq [$];
  int            gnt_free_at;
  int            last_rd;
  bit            wb_occ;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NW; i++) ref_regs[i] = '0;
    rq.delete();
    gnt_free_at = 0;
    last_rd     = -100;
    wb_occ      = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},    {31'd0, gnt},    32'd1);
    chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
    chk({tag, "_rdata"},  rdata,           32'd0);
    chk({tag, "_err"},    {31'd0, err},    32'd0);
    chk({tag, "_busy"},   {31'd0, busy},   32'd0);
  endtask

  // Called just after a falling edge: check this cycle's outputs, drive the
  // request, advance the model, then move to the next falling edge.
  task automatic step(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit            exp_gnt, exp_rv, exp_busy, launch, wcap;
    logic [DW-1:0] exp_data;
    bit            exp_e;
    rsp_t          rs;
    exp_gnt  = (cyc >= gnt_free_at);
    exp_rv   = (rq.size() > 0) && (rq[0].due == cyc);
    exp_data = exp_rv ? rq[0].data : '0;
    exp_e    = exp_rv ? rq[0].err : 1'b0;
    exp_busy = wb_occ || (cyc <= last_rd + RL);
    chk("gnt",    {31'd0, gnt},    {31'd0, exp_gnt});
    chk("rvalid", {31'd0, rvalid}, {31'd0, exp_rv});
    chk("rdata",  rdata,           exp_data);
    chk("err",    {31'd0, err},    {31'd0, exp_e});
    chk("busy",   {31'd0, busy},   {31'd0, exp_busy});
    if (exp_rv) void'(rq.pop_front());

    req = r; we = w; addr = a; wdata = d;
    launch = 1'b0;
    wcap   = 1'b0;
    if (r && exp_gnt) begin
      if (w) begin
        if (a != 0 && int'(a) < NW) begin
          ref_regs[a] = d;
          wcap = 1'b1;
        end
      end else begin
        rs.due  = cyc + RL;
        rs.err  = (int'(a) >= NW);
        rs.data = (a == 0 || int'(a) >= NW) ? '0 : ref_regs[a];
        rq.push_back(rs);
        last_rd     = cyc;
        gnt_free_at = cyc + RL;
        launch      = 1'b1;
      end
    end
    wb_occ = wcap | (wb_occ & launch);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    model_clear();
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // Reads after reset, including entry 0
    step(1'b1, 1'b0, 5'd5, '0);
    idle(3);
    step(1'b1, 1'b0, 5'd0, '0);
    idle(3);

    // Write then immediate read (forward), then read again from the array
    step(1'b1, 1'b1, 5'd7, 32'hDEADBEEF);
    step(1'b1, 1'b0, 5'd7, '0);
    idle(3);
    step(1'b1, 1'b0, 5'd7, '0);
    idle(4);

    // Back-to-back writes with an in-place overwrite
    step(1'b1, 1'b1, 5'd9,  32'h1);
    step(1'b1, 1'b1, 5'd9,  32'h2);
    step(1'b1, 1'b1, 5'd10, 32'h3);
    step(1'b1, 1'b0, 5'd9,  '0);
    step(1'b1, 1'b0, 5'd10, '0);   // held request while gnt is low
    step(1'b1, 1'b0, 5'd10, '0);
    step(1'b1, 1'b0, 5'd10, '0);
    idle(4);

    // Out-of-range read errors; out-of-range and entry-0 writes are dropped
    step(1'b1, 1'b0, 5'd20, '0);
    idle(3);
    step(1'b1, 1'b1, 5'd20, 32'hCAFE0001);
    step(1'b1, 1'b1, 5'd0,  32'hCAFE0002);
    idle(2);
    step(1'b1, 1'b0, 5'd0, '0);
    idle(4);

    // Reset while a read is in flight and a write is buffered
    step(1'b1, 1'b1, 5'd4, 32'hA5A55A5A);
    step(1'b1, 1'b0, 5'd4, '0);
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    model_clear();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk_reset_outputs("inrst");
    rst_n = 1'b1;
    idle(4);
    step(1'b1, 1'b0, 5'd4, '0);
    idle(4);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
           AW'($urandom_range(0, 19)), $urandom);
    end
    idle(6);
    chk("drained", 32'(rq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ibex_l2_regfile_resp.md
# ibex_l2_regfile_resp

Responder end of the L1/L2 register-file split: a single-port L2 register store serving read and write requests from the L1 register cache front-end. It holds the architectural registers that are not resident in L1, with a configurable read latency that models the SRAM macro. A one-entry posted write buffer with read forwarding lets writes retire without stalling the core's writeback. The block sits below the register-file front-end and returns data plus a valid strobe that the front-end uses to release its stall.

## Interface
Parameters:
- DataWidth, 32, register width.
- AddrWidth, 5, request address width.
- NumWords, 32, implemented registers; 16 for RV32E; must be ≤ 2**AddrWidth.
- ReadLatency, 1, cycles from read accept to rvalid_o; legal values 1..3.

Ports:
- clk_i  in  1  clock; the only clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  request valid.
- we_i  in  1  1 = write, 0 = read; qualified by req_i.
- addr_i  in  AddrWidth  register index.
- wdata_i  in  DataWidth  write data.
- gnt_o  out  1  request accepted this cycle when req_i & gnt_o.
- rvalid_o  out  1  read response strobe, one cycle per accepted read.
- rdata_o  out  DataWidth  read data, valid when rvalid_o = 1, otherwise 0.
- err_o  out  1  with rvalid_o: read address ≥ NumWords.
- busy_o  out  1  read in flight or write buffer occupied.

## Operation
- Storage: NumWords × DataWidth flop array, one access per cycle (read launch or write commit). Entry 0 is never written and always reads 0.
- FSM states: IDLE, RD_WAIT.
  - IDLE: gnt_o = 1. An accepted read launches, samples data, loads the latency counter with ReadLatency-1, and moves to RD_WAIT if ReadLatency > 1. Otherwise it stays in IDLE.
  - RD_WAIT: gnt_o = 0. The counter decrements each cycle. At 0, return to IDLE.
- Read data source, sampled in the accept cycle:
  - addr 0: data 0.
  - addr ≥ NumWords: data 0 and err_o = 1.
  - Write buffer valid and matching the address: buffer data (forward).
  - Otherwise: array[addr].
- Sampled data passes through a ReadLatency-deep pipeline to rdata_o/rvalid_o/err_o.
- Writes:
  - An accepted write with addr 0 or addr ≥ NumWords is dropped silently. No err_o is raised.
  - Otherwise the write is captured in the buffer (wb_valid, wb_addr, wb_data).
- Buffer drain: the buffer commits to the array in any cycle with no read launch. This includes RD_WAIT cycles and the cycle in which a new write is captured. In that case, the old entry commits and the new one is captured in the same edge.
- A write to the buffered address overwrites the buffer in place, so only the newest value commits.
- A write is never blocked when gnt_o = 1. A read launch with the buffer full defers the drain to the next non-read cycle.
- busy_o = wb_valid | (state != IDLE) | any rvalid pipeline stage occupied.

## Timing
- Reset values:
  - gnt_o = 1; rvalid_o, err_o, busy_o = 0; rdata_o = 0.
  - State is IDLE and the counter is 0. The pipeline, the buffer and all array entries are cleared to 0.
- Read accepted at edge T: rvalid_o is high in cycle T+ReadLatency for exactly one cycle.
- gnt_o is low in cycles T+1 .. T+ReadLatency-1. It is high again in the rvalid cycle, so reads can run back-to-back every ReadLatency cycles. With ReadLatency = 1, one read per cycle.
- A write accepted at T is visible to a read accepted at T+1 (forwarded). It is in the array at the latest by the first non-read edge after T.
- Reset asserted mid-read: the response is lost and rvalid_o is never raised. A pending buffered write is lost. The front-end must not rely on in-flight state across reset.
- req_i while gnt_o = 0: ignored. The requester holds its request until granted.

## Test plan
- After reset, read addr 5 (ReadLatency=1) -> rvalid_o at T+1, rdata_o = 0, err_o = 0. Read addr 0 -> 0.
- Write addr 7 = 0xDEADBEEF at T, read addr 7 at T+1 -> rvalid_o at T+2, rdata_o = 0xDEADBEEF (forward). Idle 1 cycle, then read again -> same value from the array, wb empty, busy_o = 0.
- ReadLatency=3: read addr 3 at T -> gnt_o = 0 in T+1, T+2; rvalid_o and gnt_o = 1 at T+3. A second read accepted at T+3 -> rvalid_o at T+6.
- Writes to addrs 9, 9, 10 on consecutive cycles, each with 0x1, 0x2, 0x3 -> all granted. Reads then return addr9 = 0x2 and addr10 = 0x3.
- NumWords=16: read addr 20 -> rvalid_o with err_o = 1, rdata_o = 0. Write addr 20 or addr 0 -> granted, array unchanged, busy_o stays 0.
- Write addr 4, then read in flight with ReadLatency=2, then assert rst_ni low -> all outputs at reset values, no rvalid_o. A read of addr 4 after reset returns 0.
